// File: rtl/elevator_pkg.sv
// Shared types and motion encodings for the elevator scheduler.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DOOR = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Encodings shared with the downstream motion controller.
    localparam logic [1:0] MOT_STOP = 2'b00;
    localparam logic [1:0] MOT_UP   = 2'b01;
    localparam logic [1:0] MOT_DOWN = 2'b10;

    function automatic logic [1:0] motion_code(input state_t s);
        logic [1:0] code;
        code = MOT_STOP;
        if (s == UP) begin
            code = MOT_UP;
        end else if (s == DOWN) begin
            code = MOT_DOWN;
        end
        return code;
    endfunction

endpackage

// File: rtl/elevator_call_scan.sv
// Splits a call vector into above / below / here flags
// relative to a given floor.
module elevator_call_scan
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = 4,
    parameter int FLOOR_W  = $clog2(N_FLOORS)
) (
    input  logic [N_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]  floor,
    output logic                above,
    output logic                below,
    output logic                here
);

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        here  = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i > int'(floor)) begin
                above = above | pending[i];
            end else if (i < int'(floor)) begin
                below = below | pending[i];
            end else begin
                here = pending[i];
            end
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car collective (SCAN) call scheduler: latches calls,
// commands motion, tracks position and times the door dwell.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int N_FLOORS    = 4,
    parameter int FLOOR_W     = $clog2(N_FLOORS),
    parameter int DOOR_CYCLES = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] call_req,
    input  logic                floor_reached,
    output logic [1:0]          motion_status,
    output logic [FLOOR_W-1:0]  current_floor,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending,
    output logic                busy
);

    localparam int TIMER_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] DOOR_LOAD = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);

    state_t              state;
    state_t              state_nxt;
    dir_t                dir_pref;
    dir_t                dir_nxt;
    logic [TIMER_W-1:0]  timer;
    logic [TIMER_W-1:0]  timer_nxt;
    logic [FLOOR_W-1:0]  floor_nxt;
    logic [FLOOR_W-1:0]  arrive_floor;
    logic [N_FLOORS-1:0] merged;
    logic [N_FLOORS-1:0] clear_mask;
    logic [N_FLOORS-1:0] pending_nxt;
    logic                idle_above;
    logic                idle_below;
    logic                idle_here;
    logic                arr_above;
    logic                arr_below;
    logic                arr_here;
    logic                at_limit;

    assign merged = pending | call_req;

    // Dispatch decisions from IDLE look only at latched calls.
    elevator_call_scan #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_idle_scan (
        .pending (pending),
        .floor   (current_floor),
        .above   (idle_above),
        .below   (idle_below),
        .here    (idle_here)
    );

    // Arrival decisions also see calls landing on the same edge.
    elevator_call_scan #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_arrive_scan (
        .pending (merged),
        .floor   (arrive_floor),
        .above   (arr_above),
        .below   (arr_below),
        .here    (arr_here)
    );

    always_comb begin
        arrive_floor = current_floor;
        at_limit     = 1'b0;
        if (floor_reached && state == UP) begin
            if (current_floor == TOP_FLOOR) begin
                at_limit = 1'b1;
            end else begin
                arrive_floor = current_floor + FLOOR_W'(1);
            end
        end else if (floor_reached && state == DOWN) begin
            if (current_floor == '0) begin
                at_limit = 1'b1;
            end else begin
                arrive_floor = current_floor - FLOOR_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_pref;
        timer_nxt = timer;
        floor_nxt = current_floor;
        unique case (state)
            IDLE: begin
                if (idle_here) begin
                    state_nxt = DOOR;
                    timer_nxt = DOOR_LOAD;
                end else if (idle_above && (!idle_below || dir_pref == DIR_UP)) begin
                    state_nxt = UP;
                    dir_nxt   = DIR_UP;
                end else if (idle_below) begin
                    state_nxt = DOWN;
                    dir_nxt   = DIR_DOWN;
                end
            end
            UP, DOWN: begin
                if (floor_reached) begin
                    floor_nxt = arrive_floor;
                    if (arr_here) begin
                        state_nxt = DOOR;
                        timer_nxt = DOOR_LOAD;
                    end else if (state == UP ? !arr_above : !arr_below) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DOOR: begin
                if (call_req[current_floor]) begin
                    timer_nxt = DOOR_LOAD;
                end else if (timer == '0) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer - TIMER_W'(1);
                end
            end
        endcase

        // A call is served, never latched, while the door is open at its floor.
        clear_mask = '0;
        if (state_nxt == DOOR) begin
            clear_mask[floor_nxt] = 1'b1;
        end
        pending_nxt = merged & ~clear_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            dir_pref      <= DIR_UP;
            timer         <= '0;
            current_floor <= '0;
            pending       <= '0;
            motion_status <= MOT_STOP;
            door_open     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            dir_pref      <= dir_nxt;
            timer         <= timer_nxt;
            current_floor <= floor_nxt;
            pending       <= pending_nxt;
            motion_status <= motion_code(state_nxt);
            door_open     <= (state_nxt == DOOR);
            busy          <= (state_nxt != IDLE);
        end
    end

    limit_pulse: assert property (@(posedge clk) disable iff (rst) !at_limit);
    no_code_11: assert property (@(posedge clk) disable iff (rst) motion_status != 2'b11);
    door_excl: assert property (@(posedge clk) disable iff (rst)
        !(door_open && motion_status != MOT_STOP));

endmodule

// File: tb/tb_elevator_scheduler.sv
// Randomized and directed bench for elevator_scheduler against
// a call-list / dwell-countdown reference model.
module tb_elevator_scheduler;

    localparam int N  = 4;
    localparam int FW = 2;
    localparam int DC = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  call_req;
    logic          floor_reached;
    logic [1:0]    motion_status;
    logic [FW-1:0] current_floor;
    logic          door_open;
    logic [N-1:0]  pending;
    logic          busy;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    typedef enum {M_IDLE, M_UP, M_DOWN, M_DOOR} mode_t;
    mode_t      m_mode;
    int         m_floor;
    bit [N-1:0] m_pend;
    bit         m_head_up;
    int         m_left;

    elevator_scheduler #(
        .N_FLOORS    (N),
        .FLOOR_W     (FW),
        .DOOR_CYCLES (DC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .call_req      (call_req),
        .floor_reached (floor_reached),
        .motion_status (motion_status),
        .current_floor (current_floor),
        .door_open     (door_open),
        .pending       (pending),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit any_above(input bit [N-1:0] p, input int f);
        for (int i = f + 1; i < N; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_below(input bit [N-1:0] p, input int f);
        for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_floor   = 0;
        m_pend    = '0;
        m_head_up = 1'b1;
        m_left    = 0;
    endtask

    task automatic model_edge(input bit [N-1:0] req, input bit fr);
        bit [N-1:0] seen;
        seen = m_pend | req;
        case (m_mode)
            M_IDLE: begin
                if (m_pend[m_floor]) begin
                    m_mode = M_DOOR;
                    m_left = DC;
                end else if (any_above(m_pend, m_floor) &&
                             (m_head_up || !any_below(m_pend, m_floor))) begin
                    m_mode    = M_UP;
                    m_head_up = 1'b1;
                end else if (any_below(m_pend, m_floor)) begin
                    m_mode    = M_DOWN;
                    m_head_up = 1'b0;
                end
            end
            M_UP, M_DOWN: begin
                if (fr) begin
                    if (m_mode == M_UP) m_floor = (m_floor < N - 1) ? m_floor + 1 : m_floor;
                    else m_floor = (m_floor > 0) ? m_floor - 1 : 0;
                    if (seen[m_floor]) begin
                        m_mode = M_DOOR;
                        m_left = DC;
                    end else if (m_mode == M_UP ? !any_above(seen, m_floor)
                                                : !any_below(seen, m_floor)) begin
                        m_mode = M_IDLE;
                    end
                end
            end
            M_DOOR: begin
                if (req[m_floor]) begin
                    m_left = DC;
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            end
        endcase
        if (m_mode == M_DOOR) m_pend = seen & ~(N'(1) << m_floor);
        else m_pend = seen;
    endtask

    task automatic compare_outputs();
        logic [1:0] em;
        em = (m_mode == M_UP) ? 2'b01 : (m_mode == M_DOWN) ? 2'b10 : 2'b00;
        check({phase, "/motion"}, 32'(motion_status), 32'(em));
        check({phase, "/floor"}, 32'(current_floor), 32'(m_floor));
        check({phase, "/door"}, 32'(door_open), 32'(m_mode == M_DOOR));
        check({phase, "/pending"}, 32'(pending), 32'(m_pend));
        check({phase, "/busy"}, 32'(busy), 32'(m_mode != M_IDLE));
    endtask

    task automatic step(input logic [N-1:0] req, input logic fr);
        call_req      = req;
        floor_reached = fr;
        @(posedge clk);
        model_edge(req, fr);
        #1;
        call_req      = '0;
        floor_reached = 1'b0;
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic do_reset();
        call_req      = '0;
        floor_reached = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic bit model_moving();
        return (m_mode == M_UP) || (m_mode == M_DOWN);
    endfunction

    initial begin
        int         door_len;
        int         mot_cnt;
        int         door_floors[$];
        logic       prev_door;
        logic [N-1:0] req;
        logic       fr;

        rst           = 1'b1;
        call_req      = '0;
        floor_reached = 1'b0;
        model_reset();
        @(negedge clk);

        phase = "t1";
        do_reset();
        step(4'b1000, 1'b0);
        check("t1_latched", 32'(pending), 32'(4'b1000));
        check("t1_still", 32'(motion_status), 32'(2'b00));
        step('0, 1'b0);
        check("t1_mot_up", 32'(motion_status), 32'(2'b01));
        repeat (3) step('0, 1'b1);
        check("t1_floor", 32'(current_floor), 32'(3));
        check("t1_pend_clr", 32'(pending), 32'(0));
        door_len = 0;
        for (int i = 0; i < 6; i++) begin
            if (door_open) door_len++;
            step('0, 1'b0);
        end
        check("t1_door_len", 32'(door_len), 32'(DC));
        check("t1_busy", 32'(busy), 32'(0));

        phase = "t2";
        do_reset();
        mot_cnt = 0;
        step(4'b0001, 1'b0);
        if (motion_status != 2'b00) mot_cnt++;
        step('0, 1'b0);
        check("t2_door", 32'(door_open), 32'(1));
        for (int i = 0; i < 5; i++) begin
            if (motion_status != 2'b00) mot_cnt++;
            step('0, 1'b0);
        end
        check("t2_no_motion", 32'(mot_cnt), 32'(0));

        phase = "t3";
        do_reset();
        step(4'b1000, 1'b0);
        step('0, 1'b0);
        step(4'b0001, 1'b1);
        check("t3_pend", 32'(pending), 32'(4'b1001));
        check("t3_up", 32'(motion_status), 32'(2'b01));
        prev_door = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step('0, model_moving());
            if (door_open && !prev_door) door_floors.push_back(int'(current_floor));
            prev_door = door_open;
        end
        check("t3_stops", 32'(door_floors.size()), 32'(2));
        if (door_floors.size() == 2) begin
            check("t3_first", 32'(door_floors[0]), 32'(3));
            check("t3_second", 32'(door_floors[1]), 32'(0));
        end

        phase = "t4";
        do_reset();
        step(4'b0100, 1'b0);
        step('0, 1'b0);
        step('0, 1'b1);
        step('0, 1'b1);
        check("t4_at2", 32'(current_floor), 32'(2));
        step('0, 1'b0);
        step('0, 1'b0);
        check("t4_door_pre", 32'(door_open), 32'(1));
        step(4'b0100, 1'b0);
        door_len = 0;
        for (int i = 0; i < 6; i++) begin
            if (door_open) door_len++;
            check("t4_pend2", 32'(pending[2]), 32'(0));
            step('0, 1'b0);
        end
        check("t4_door_len", 32'(door_len), 32'(DC));

        phase = "t5";
        do_reset();
        step(4'b1000, 1'b0);
        step('0, 1'b0);
        step('0, 1'b1);
        step(4'b0100, 1'b1);
        check("t5_floor", 32'(current_floor), 32'(2));
        check("t5_door", 32'(door_open), 32'(1));
        check("t5_stop", 32'(motion_status), 32'(2'b00));
        check("t5_pend", 32'(pending), 32'(4'b1000));

        phase = "t6";
        do_reset();
        step(4'b0100, 1'b0);
        step('0, 1'b0);
        step('0, 1'b1);
        step('0, 1'b1);
        repeat (3) step('0, 1'b0);
        step(4'b0001, 1'b0);
        step('0, 1'b0);
        check("t6_down", 32'(motion_status), 32'(2'b10));
        step('0, 1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("t6_rst_mot", 32'(motion_status), 32'(0));
        check("t6_rst_floor", 32'(current_floor), 32'(0));
        check("t6_rst_pend", 32'(pending), 32'(0));
        check("t6_rst_door", 32'(door_open), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step('0, 1'b1);
        check("t6_ignored", 32'(current_floor), 32'(0));

        phase = "rnd";
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            req = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            if (model_moving()) fr = ($urandom_range(0, 2) == 0);
            else fr = ($urandom_range(0, 9) == 0);
            step(req, fr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
Request scheduler and sequencer for the single-car elevator motion controller.
- Latches floor calls from hall and cab buttons.
- Picks travel direction using collective (SCAN) ordering.
- Drives the 2-bit motion command (01 up, 10 down, 00 stop).
- Tracks the car position from per-floor arrival pulses.
- Times the door-open dwell before the next dispatch.

Parameters:
N_FLOORS, 4, number of floors; floors are numbered 0..N_FLOORS-1; N_FLOORS >= 2.
FLOOR_W, $clog2(N_FLOORS), width of the floor index.
DOOR_CYCLES, 10, number of clk cycles the door stays open per stop; DOOR_CYCLES >= 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
call_req  input  N_FLOORS  one bit per floor; a 1 in any cycle registers a call for that floor (pulse or level).
floor_reached  input  1  one-cycle pulse: the car has moved exactly one floor in the commanded direction.
motion_status  output  2  motion command: 01 up, 10 down, 00 stop; 11 is never driven.
current_floor  output  FLOOR_W  registered car position.
door_open  output  1  high while the door dwell is in progress.
pending  output  N_FLOORS  latched outstanding calls.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, any state, mid-move included):
  - state=IDLE, current_floor=0, pending=0, dir_pref=UP, door timer=0.
  - motion_status=00, door_open=0, busy=0.
- All outputs are registered.
- Pending register:
  - Each edge: pending <= (pending | call_req) & ~clear_mask.
  - clear_mask has only the current_floor bit set, and only on edges where the state enters or remains in DOOR.
  - A call for the current floor while in DOOR restarts the door timer and is never latched.
- States: IDLE, UP, DOWN, DOOR.
- IDLE (evaluates registered pending only):
  - pending[current_floor]: go to DOOR.
  - Else let above = any pending bit above current_floor, below = any pending bit below it.
  - above & below: take dir_pref.
  - Only above: UP, set dir_pref=UP.
  - Only below: DOWN, set dir_pref=DOWN.
  - Neither: stay in IDLE.
- Call latency: a call sampled at edge k appears in pending at edge k. Motion_status or door_open changes at edge k+1 (2-edge latency from call to command).
- UP (motion_status=01):
  - On floor_reached, current_floor increments.
  - If pending[new floor]: go to DOOR.
  - Else if no pending bits above the new floor: go to IDLE.
  - Else stay in UP.
- DOWN: mirror of UP with a decrement.
- floor_reached handling:
  - Ignored in IDLE and DOOR.
  - At the top floor in UP or floor 0 in DOWN: current_floor saturates and the event is flagged in assertions only.
- DOOR (motion_status=00, door_open=1):
  - Entry loads the timer with DOOR_CYCLES-1 and it decrements each cycle.
  - Timer reaching 0 with no same-floor call: go to IDLE and keep dir_pref.
  - Door open lasts exactly DOOR_CYCLES cycles absent re-calls.
- Simultaneous events: call_req for the floor being arrived at in the same edge as floor_reached is honoured (the car stops there).
- Multiple call_req bits set in one cycle are all latched.
- Invariants: motion_status!=00 only in UP or DOWN; door_open and motion_status!=00 are never both true.

Decomposition:
- Shared package elevator_pkg holds:
  - The state enum (IDLE, UP, DOWN, DOOR).
  - Motion code constants MOT_STOP=2'b00, MOT_UP=2'b01, MOT_DOWN=2'b10 (the existing motion controller encodings).
- One natural sub-module: elevator_call_scan. It is combinational: pending + current_floor -> above, below, here flags.
- The door timer stays inline.

Test Plan:
- Reset, then call_req=4'b1000 for 1 cycle (N=4, DOOR_CYCLES=3) -> motion_status=01 two edges later. After 3 floor_reached pulses: current_floor=3, door_open=1 for 3 cycles, pending=0, then IDLE with busy=0.
- At floor 0, call_req=4'b0001 -> DOOR with no motion; motion_status stays 00 throughout.
- Car at floor 1 moving UP with pending=4'b1001, dir_pref=UP -> serves floor 3 first, then DOWN to floor 0; two door cycles in that order.
- During DOOR at floor 2, call_req=4'b0100 on the last timer cycle -> timer reloads, door_open lasts 3 more cycles, and pending[2] is never set.
- Moving UP toward floor 2: call_req=4'b0100 asserted on the same edge as the floor_reached that makes current_floor=2 -> stops at 2 and door opens next cycle.
- rst asserted mid-DOWN between floors -> immediately motion_status=00, current_floor=0, pending=0. Subsequent floor_reached pulses are ignored.
